// File: rtl/i_softmax_row.sv
`default_nettype none
// ============================================================================
//  Module      : i_softmax_row_iexp
//  Description : Integer exponential for non-positive arguments. The argument
//                is split into x = r - z*ln2, where z comes from a fixed-point
//                multiply by 1/ln2. A second-order polynomial approximates
//                exp(r), and the result is then shifted right by z:
//                    z    = ((-x) * q_ln2_neg_inv) >> 16
//                    r    = x + z * q_ln2
//                    poly = (r + q_b)^2 + q_c
//                    y    = (z >= 2*DATA_W) ? 0 : poly >>> z
//                All intermediate values are 2*DATA_W bits wide. y is the
//                lower DATA_W bits of the shifted value.
//  Ports       : x                    signed argument (expected <= 0)
//                q_b, q_c             polynomial constants (signed)
//                q_ln2                ln2 in the input scale (unsigned)
//                q_ln2_neg_inv        1/ln2 in Q.16 (unsigned)
//                y                    signed exp result (DATA_W)
//  Revision    : 1.0 - initial release
// ============================================================================
module i_softmax_row_iexp #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] q_b,
    input  logic [DATA_W-1:0] q_c,
    input  logic [DATA_W-1:0] q_ln2,
    input  logic [DATA_W-1:0] q_ln2_neg_inv,
    output logic [DATA_W-1:0] y
);
    localparam int W2          = 2 * DATA_W;
    localparam int SH_W        = $clog2(W2);
    localparam int c_inv_shift = 16;
    localparam logic [W2-1:0] c_shift_lim = W2'(W2);

    logic [DATA_W-1:0]        w_neg;
    logic [W2-1:0]            w_prod;
    logic [W2-1:0]            w_z;
    logic [W2-1:0]            w_zq;
    logic signed [W2-1:0]     w_x_ext;
    logic signed [W2-1:0]     w_r;
    logic signed [W2-1:0]     w_rb;
    logic signed [W2-1:0]     w_poly;

    // For x <= 0, the value -x fits in DATA_W unsigned bits, including the most negative x.
    assign w_neg   = -x;
    assign w_prod  = {{DATA_W{1'b0}}, w_neg} * {{DATA_W{1'b0}}, q_ln2_neg_inv};
    assign w_z     = w_prod >> c_inv_shift;
    assign w_zq    = w_z * {{DATA_W{1'b0}}, q_ln2};
    assign w_x_ext = {{DATA_W{x[DATA_W-1]}}, x};
    assign w_r     = w_x_ext + $signed(w_zq);
    assign w_rb    = w_r + $signed({{DATA_W{q_b[DATA_W-1]}}, q_b});
    assign w_poly  = w_rb * w_rb + $signed({{DATA_W{q_c[DATA_W-1]}}, q_c});

    // A shift of 2*DATA_W or more would underflow completely, so the output is forced to zero.
    assign y = (w_z >= c_shift_lim) ? '0
                                    : DATA_W'(w_poly >>> w_z[SH_W-1:0]);
endmodule

// ============================================================================
//  Module      : i_softmax_row
//  Description : Row-oriented integer softmax. The engine first buffers one
//                row of signed logits and tracks the running maximum. An
//                accumulate pass then sums exp(x - max). A normalise pass
//                follows and emits exp(x - max) * 2^OUT_FRAC / sum for each
//                element, in input order.
//  Ports       : CLK, RST_n                 clock, async active-low reset
//                q_b, q_c, q_ln2,
//                q_ln2_neg_inv              exp constants (static while busy)
//                abort                      synchronous row discard
//                in_valid/in_ready/in_data/
//                in_last                    logit input stream
//                out_valid/out_ready/
//                out_data/out_last          probability output stream
//                busy                       engine not idle
//  Revision    : 1.0 - initial release
// ============================================================================
module i_softmax_row #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 64,
    parameter int OUT_FRAC = 15,
    parameter int ACC_W    = DATA_W + $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic [DATA_W-1:0] q_b,
    input  logic [DATA_W-1:0] q_c,
    input  logic [DATA_W-1:0] q_ln2,
    input  logic [DATA_W-1:0] q_ln2_neg_inv,
    input  logic              abort,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam int NUM_W = ACC_W + OUT_FRAC;

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_load = 2'd1;
    localparam logic [1:0] c_acc  = 2'd2;
    localparam logic [1:0] c_norm = 2'd3;

    localparam logic [NUM_W-1:0] c_one      = NUM_W'(1) << OUT_FRAC;
    localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(DEPTH - 1);

    logic [1:0]        r_state;
    logic [DATA_W-1:0] r_max;
    logic [ACC_W-1:0]  r_acc;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  r_idx;
    logic [CNT_W-1:0]  r_len;
    logic [DATA_W-1:0] r_buf [DEPTH];

    logic              w_in_hs;
    logic              w_out_hs;
    logic [DATA_W-1:0] w_rd;
    logic [DATA_W-1:0] w_diff;
    logic [DATA_W-1:0] w_exp;
    logic [DATA_W-1:0] w_e;
    logic [CNT_W-1:0]  w_last_idx;
    logic              w_at_last;
    logic [NUM_W-1:0]  w_num;
    logic [NUM_W-1:0]  w_den;
    logic [NUM_W-1:0]  w_quot;
    logic [NUM_W-1:0]  w_prob;
    logic [IDX_W-1:0]  w_wr_addr;

    assign in_ready  = (r_state == c_idle) || (r_state == c_load);
    assign out_valid = (r_state == c_norm);
    assign busy      = (r_state != c_idle);

    // abort overrides both handshakes in the same cycle.
    assign w_in_hs  = in_valid  & in_ready  & ~abort;
    assign w_out_hs = out_valid & out_ready & ~abort;

    assign w_last_idx = r_len - CNT_W'(1);
    assign w_at_last  = (r_idx == w_last_idx);

    // One exp datapath is shared. The accumulate pass uses it to build the sum,
    // and the normalise pass uses it again to recompute the numerator.
    assign w_rd   = r_buf[r_idx[IDX_W-1:0]];
    assign w_diff = w_rd - r_max;

    i_softmax_row_iexp #(
        .DATA_W (DATA_W)
    ) u_iexp (
        .x             (w_diff),
        .q_b           (q_b),
        .q_c           (q_c),
        .q_ln2         (q_ln2),
        .q_ln2_neg_inv (q_ln2_neg_inv),
        .y             (w_exp)
    );

    // A negative polynomial result is meaningless as a probability weight, so it is clamped to zero.
    assign w_e = w_exp[DATA_W-1] ? '0 : w_exp;

    assign w_num  = {{(ACC_W - DATA_W){1'b0}}, w_e, {OUT_FRAC{1'b0}}};
    // The divisor is kept non-zero, and the acc == 0 case is masked at the output.
    assign w_den  = (r_acc == '0) ? NUM_W'(1) : {{OUT_FRAC{1'b0}}, r_acc};
    assign w_quot = w_num / w_den;
    assign w_prob = (w_quot > c_one) ? c_one : w_quot;

    assign out_data = ((r_state == c_norm) && (r_acc != '0)) ? DATA_W'(w_prob) : '0;
    assign out_last = (r_state == c_norm) && w_at_last;

    // The first beat of a row always lands in slot 0.
    assign w_wr_addr = (r_state == c_idle) ? '0 : r_cnt[IDX_W-1:0];

    // The row buffer holds no reset state. Its contents are don't-care outside a row.
    always_ff @(posedge CLK) begin
        if (w_in_hs) begin
            r_buf[w_wr_addr] <= in_data;
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_state <= c_idle;
            r_max   <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_len   <= '0;
        end else if (abort) begin
            r_state <= c_idle;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (w_in_hs) begin
                        // The first beat seeds max directly and is never compared against a stale value.
                        r_max <= in_data;
                        r_cnt <= CNT_W'(1);
                        r_idx <= '0;
                        r_acc <= '0;
                        if (in_last) begin
                            r_len   <= CNT_W'(1);
                            r_state <= c_acc;
                        end else begin
                            r_state <= c_load;
                        end
                    end
                end
                c_load: begin
                    if (w_in_hs) begin
                        if ($signed(in_data) > $signed(r_max)) begin
                            r_max <= in_data;
                        end
                        r_cnt <= r_cnt + CNT_W'(1);
                        // Filling the last buffer slot acts as an implicit end of row.
                        if (in_last || (r_cnt == c_last_cnt)) begin
                            r_len   <= r_cnt + CNT_W'(1);
                            r_idx   <= '0;
                            r_acc   <= '0;
                            r_state <= c_acc;
                        end
                    end
                end
                c_acc: begin
                    r_acc <= r_acc + {{(ACC_W - DATA_W){1'b0}}, w_e};
                    if (w_at_last) begin
                        r_idx   <= '0;
                        r_state <= c_norm;
                    end else begin
                        r_idx <= r_idx + CNT_W'(1);
                    end
                end
                c_norm: begin
                    if (w_out_hs) begin
                        if (w_at_last) begin
                            r_idx   <= '0;
                            r_cnt   <= '0;
                            r_state <= c_idle;
                        end else begin
                            r_idx <= r_idx + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= c_idle;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_i_softmax_row.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i_softmax_row
//  Description : Scoreboard bench for i_softmax_row. Stimulus pushes the
//                expected probabilities, and a monitor pops and compares them
//                on every output handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i_softmax_row;
    localparam int DW    = 32;
    localparam int DEPTH = 64;
    localparam int OF    = 15;

    localparam longint QB   = 100;
    localparam longint QC   = 1000;
    localparam longint QLN2 = 10;
    localparam longint QINV = 6554;

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } exp_t;

    logic          CLK = 1'b0;
    logic          RST_n = 1'b0;
    logic [DW-1:0] q_b, q_c, q_ln2, q_ln2_neg_inv;
    logic          abort;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          busy;

    always #5 CLK = ~CLK;

    i_softmax_row #(
        .DATA_W   (DW),
        .DEPTH    (DEPTH),
        .OUT_FRAC (OF)
    ) dut (
        .CLK           (CLK),
        .RST_n         (RST_n),
        .q_b           (q_b),
        .q_c           (q_c),
        .q_ln2         (q_ln2),
        .q_ln2_neg_inv (q_ln2_neg_inv),
        .abort         (abort),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_last       (in_last),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_last      (out_last),
        .busy          (busy)
    );

    int     errors = 0;
    int     checks = 0;
    int     cyc = 0;
    int     first_valid_cyc = -1;
    int     t_last = 0;
    longint sum_act = 0;
    exp_t   sb[$];
    logic signed [DW-1:0] row [DEPTH];

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Golden integer exp, written from the algorithm definition.
    function automatic longint iexp(input logic signed [DW-1:0] x);
        longint          xs;
        longint unsigned nz;
        longint unsigned z;
        longint          r;
        longint          rb;
        longint          poly;
        longint          sh;
        logic [DW-1:0]   y;
        xs   = x;
        nz   = longint'(-xs);
        z    = (nz * QINV) >> 16;
        r    = xs + longint'(z * QLN2);
        rb   = r + QB;
        poly = rb * rb + QC;
        sh   = (z >= 64) ? 0 : (poly >>> z);
        y    = sh[DW-1:0];
        if (y[DW-1]) y = '0;
        return longint'(y);
    endfunction

    task automatic push_model(input int n);
        logic signed [DW-1:0] mx;
        longint               e [DEPTH];
        longint               acc;
        longint               q;
        exp_t                 item;
        mx  = row[0];
        acc = 0;
        for (int i = 1; i < n; i++) if (row[i] > mx) mx = row[i];
        for (int i = 0; i < n; i++) begin
            e[i] = iexp(row[i] - mx);
            acc += e[i];
        end
        for (int i = 0; i < n; i++) begin
            q = (acc == 0) ? 0 : (e[i] << OF) / acc;
            if (q > (64'sd1 << OF)) q = 64'sd1 << OF;
            item.d = q[DW-1:0];
            item.l = (i == n - 1);
            sb.push_back(item);
        end
    endtask

    task automatic push_exp(input longint d, input logic l);
        exp_t item;
        item.d = d[DW-1:0];
        item.l = l;
        sb.push_back(item);
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic l);
        bit ok;
        ok       = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge CLK);
            if (in_ready) ok = 1;
            @(posedge CLK);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        t_last   = cyc;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL in_handshake: got no in_ready, required accept");
        end
    endtask

    task automatic wait_drain(input int limit);
        bit done;
        done = 0;
        for (int k = 0; k < limit && !done; k++) begin
            if (sb.size() == 0 && !busy) done = 1;
            else begin
                @(posedge CLK);
                #1;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic wait_valid(input int limit);
        bit seen;
        seen = 0;
        for (int k = 0; k < limit && !seen; k++) begin
            if (out_valid) seen = 1;
            else begin
                @(posedge CLK);
                #1;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL out_valid_timeout: got 0, required 1");
        end
    endtask

    initial forever begin
        @(posedge CLK);
        cyc++;
    end

    // Monitor: pops the scoreboard on each handshake and checks that the output is held during stalls.
    initial begin
        exp_t          e;
        logic          prev_valid;
        logic          stall_prev;
        logic [DW-1:0] held_d;
        logic          held_l;
        prev_valid = 1'b0;
        stall_prev = 1'b0;
        held_d     = '0;
        held_l     = 1'b0;
        forever begin
            @(negedge CLK);
            if (RST_n) begin
                if (out_valid && !prev_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
                if (stall_prev && out_valid) begin
                    checks++;
                    if (out_data !== held_d || out_last !== held_l) begin
                        errors++;
                        $display("FAIL stall_hold: got %0d/%0b, required %0d/%0b",
                                 out_data, out_last, held_d, held_l);
                    end
                end
                if (out_valid && out_ready && !abort) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_output: got %0d, required none", out_data);
                    end else begin
                        e = sb.pop_front();
                        sum_act += longint'(out_data);
                        if (out_data !== e.d || out_last !== e.l) begin
                            errors++;
                            $display("FAIL out_beat: got %0d last=%0b, required %0d last=%0b",
                                     out_data, out_last, e.d, e.l);
                        end
                    end
                end
                stall_prev = out_valid && !out_ready && !abort;
                held_d     = out_data;
                held_l     = out_last;
                prev_valid = out_valid;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        q_b           = DW'(QB);
        q_c           = DW'(QC);
        q_ln2         = DW'(QLN2);
        q_ln2_neg_inv = DW'(QINV);
        abort         = 1'b0;
        in_valid      = 1'b0;
        in_data       = '0;
        in_last       = 1'b0;
        out_ready     = 1'b0;

        // Reset values
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", busy, 0);
        RST_n = 1'b1;
        @(posedge CLK);
        #1;

        // Uniform row: exp(0) = 11000 for each element, so each output is 2^15/4
        out_ready       = 1'b1;
        first_valid_cyc = -1;
        for (int i = 0; i < 4; i++) push_exp(8192, i == 3);
        for (int i = 0; i < 4; i++) send_beat(DW'(100), i == 3);
        chk("uni_in_ready_low", in_ready, 0);
        chk("uni_busy", busy, 1);
        wait_drain(100);
        chk("uni_latency", first_valid_cyc - t_last, 4);

        // Single element
        push_exp(32768, 1'b1);
        send_beat(-32'sd50, 1'b1);
        wait_valid(20);
        @(posedge CLK);
        #1;
        chk("single_busy_drop", busy, 0);
        chk("single_pending", sb.size(), 0);

        // All-negative row: max = -3, e = 10604, 11000, 10216, acc = 31820
        push_exp(10919, 1'b0);
        push_exp(11327, 1'b0);
        push_exp(10520, 1'b1);
        send_beat(-32'sd5, 1'b0);
        send_beat(-32'sd3, 1'b0);
        send_beat(-32'sd7, 1'b1);
        wait_drain(100);
        // Next row: max = 20, e = 5500, 11000, acc = 16500
        push_exp(10922, 1'b0);
        push_exp(21845, 1'b1);
        send_beat(DW'(10), 1'b0);
        send_beat(DW'(20), 1'b1);
        wait_drain(100);

        // Full depth with an implicit last
        for (int i = 0; i < DEPTH; i++) row[i] = DW'((i * 7) % 50 - 25);
        push_model(DEPTH);
        sum_act = 0;
        for (int i = 0; i < DEPTH; i++) send_beat(row[i], 1'b0);
        chk("full_in_ready_drop", in_ready, 0);
        wait_drain(400);
        checks++;
        if (sum_act > 32768 || sum_act < 32768 - DEPTH) begin
            errors++;
            $display("FAIL full_sum: got %0d, required %0d..32768", sum_act, 32768 - DEPTH);
        end

        // Backpressure on an 8-element row
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) row[i] = DW'(-i * 9);
        push_model(8);
        for (int i = 0; i < 8; i++) send_beat(row[i], i == 7);
        for (int k = 0; k < 400 && (sb.size() != 0 || busy); k++) begin
            out_ready = 1'($urandom_range(0, 1));
            @(posedge CLK);
            #1;
        end
        chk("bp_pending", sb.size(), 0);
        chk("bp_busy", busy, 0);
        sb.delete();
        out_ready = 1'b1;

        // Abort during the load phase
        for (int i = 0; i < 3; i++) send_beat(DW'(0), 1'b0);
        abort = 1'b1;
        @(posedge CLK);
        #1;
        abort = 1'b0;
        chk("abl_busy", busy, 0);
        chk("abl_in_ready", in_ready, 1);
        chk("abl_out_valid", out_valid, 0);
        push_exp(16384, 1'b0);
        push_exp(16384, 1'b1);
        send_beat(DW'(0), 1'b0);
        send_beat(DW'(0), 1'b1);
        wait_drain(100);

        // Abort during normalise, after two outputs
        out_ready = 1'b0;
        push_exp(8192, 1'b0);
        push_exp(8192, 1'b0);
        for (int i = 0; i < 4; i++) send_beat(DW'(0), i == 3);
        wait_valid(40);
        out_ready = 1'b1;
        @(posedge CLK);
        #1;
        @(posedge CLK);
        #1;
        out_ready = 1'b0;
        abort     = 1'b1;
        @(posedge CLK);
        #1;
        abort = 1'b0;
        chk("abn_out_valid", out_valid, 0);
        chk("abn_busy", busy, 0);
        chk("abn_pending", sb.size(), 0);
        sb.delete();
        out_ready = 1'b1;
        push_exp(16384, 1'b0);
        push_exp(16384, 1'b1);
        send_beat(DW'(0), 1'b0);
        send_beat(DW'(0), 1'b1);
        wait_drain(100);

        repeat (3) @(posedge CLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/i_softmax_row.md
# i_softmax_row

Row-oriented integer softmax engine: the parametrised successor of the single-element softmax datapath. It accepts one row of up to DEPTH signed quantised logits on a valid/ready stream and buffers the row internally. It then makes two passes over the buffer, first to accumulate exp(x − max) and then to normalise, and emits one fixed-point probability per element on a second valid/ready stream. It sits between the attention score matrix-multiply and the score×V stage, and reuses the existing I_EXP unit with bits_choice(0).

## Interface
Parameters:
- DATA_W, 32, width of logits, exp results and output words
- DEPTH, 64, maximum row length; power of two, ≥ 2
- OUT_FRAC, 15, fractional bits of output probability; OUT_FRAC < DATA_W − 1
- ACC_W, DATA_W + $clog2(DEPTH), accumulator width

Ports:
- CLK  in  1  clock; all state on rising edge
- RST_n  in  1  reset, asynchronous, active-low
- q_b, q_c, q_ln2, q_ln2_neg_inv  in  DATA_W each  I-EXP constants; static while busy
- abort  in  1  synchronous row discard
- in_valid  in  1  logit valid
- in_ready  out  1  engine can accept a logit
- in_data  in  DATA_W  signed logit
- in_last  in  1  final logit of the row
- out_valid  out  1  probability valid
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  unsigned probability, Q(DATA_W−OUT_FRAC).OUT_FRAC
- out_last  out  1  final probability of the row
- busy  out  1  high in any state except IDLE

## Operation
- FSM states: IDLE, LOAD, ACC, NORM.
- IDLE:
  - in_ready = 1.
  - An accepted logit is written to buf[0] and sets max = in_data unconditionally; max is never compared against a stale or zero value.
  - Sets cnt = 1.
  - Next state is LOAD, or ACC if in_last is high on that beat.
- LOAD:
  - in_ready = 1.
  - Each accepted logit is written to buf[cnt]; max ← in_data if $signed(in_data) > $signed(max); cnt increments.
  - Go to ACC when the accepted beat has in_last, or when cnt reaches DEPTH; the latter is an implicit last, and the following beats wait on in_ready = 0.
  - Store len = number of accepted beats.
- ACC:
  - in_ready = 0.
  - idx runs 0..len−1, one element per cycle with no stall.
  - diff = buf[idx] − max, a signed subtraction that is always ≤ 0, fed to I_EXP.
  - e = I_EXP output clamped to 0 if negative; acc += e, zero-extended to ACC_W.
  - acc is cleared on entry to ACC.
  - After idx = len−1, go to NORM with idx = 0.
- NORM:
  - The exp of buf[idx] is recomputed combinationally.
  - out_data = min((e << OUT_FRAC) / acc, 2^OUT_FRAC), computed as an unsigned single-cycle divide.
  - If acc = 0, out_data = 0.
  - out_valid = 1; out_last = (idx == len−1).
  - idx advances only on out_valid & out_ready.
  - The handshake on the last element returns the FSM to IDLE.
  - out_data, out_last and idx are held stable while out_ready = 0.
- Arithmetic:
  - Max compare and diff are signed DATA_W.
  - The accumulator cannot overflow: ACC_W covers DEPTH × (2^DATA_W − 1).
  - The divide numerator is e zero-extended to ACC_W + OUT_FRAC.
- abort, in any state: next cycle the FSM is in IDLE with cnt, idx and acc cleared and out_valid = 0. Buffer contents are don't-care. abort takes priority over any handshake in the same cycle.
- Constants q_* are sampled combinationally; changing them outside IDLE is illegal and gives undefined results.

## Timing
- Reset values:
  - FSM = IDLE, in_ready = 1, out_valid = 0, out_last = 0, out_data = 0, busy = 0.
  - max, acc, cnt, idx and len = 0.
- In LOAD, one logit is accepted per cycle at full throughput.
- The ACC pass takes exactly len cycles.
- The first out_valid is asserted len cycles after the cycle in which the last logit is accepted.
- Minimum row turnaround is 3·len cycles, and 1 cycle after the final output handshake the engine accepts the next row.
- Rows do not overlap: in_ready = 0 throughout ACC and NORM.
- A row of length 1 goes IDLE → ACC (1 cycle) → NORM.
- out_valid, once asserted, stays high until the handshake or abort; it never drops on its own.

## Test plan
- Uniform row: 4 logits of value 100, out_ready tied 1 → 4 outputs of 8192 (2^15/4), out_last on the 4th, first out_valid 4 cycles after the last input beat.
- Single element: one logit −50 with in_last → one output 32768 with out_last = 1; busy drops the cycle after the handshake.
- All-negative row −5, −3, −7, then reset-free reuse: the output for −3 equals the golden I_EXP(0)·2^15/acc value, with max initialised from the first element rather than 0. A second row 10, 20 then produces probabilities using max = 20.
- Full depth: DEPTH beats with no in_last → in_ready drops after beat DEPTH, DEPTH outputs with out_last on the last, and the probabilities sum to within DEPTH LSB of 32768 against the golden model.
- Backpressure: random out_ready on an 8-element row → out_data/out_last are stable while stalled, no element is lost or duplicated, and the output order matches the input order.
- Abort mid-LOAD (after 3 of 6 beats) and mid-NORM (after 2 outputs) → IDLE next cycle, out_valid = 0; a subsequent 2-element row [0, 0] yields 16384, 16384.
